// File: rtl/mram_ctrl_pkg.sv
// Shared definitions for the MRAM read sequencer and its helpers.
//   - state_e   : burst controller FSM encoding
//   - WS_*      : word-select codes shared with the serializer
//   - BITS_*    : serial bit counts per word-select mode
//   - bits_for  : maps a word-select code to its serial bit count
package mram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ADDR  = 3'd1,
        ST_LOAD  = 3'd2,
        ST_SHIFT = 3'd3,
        ST_NEXT  = 3'd4,
        ST_DONE  = 3'd5
    } state_e;

    localparam logic [1:0] WS_NONE = 2'b00;
    localparam logic [1:0] WS_LOW  = 2'b01;
    localparam logic [1:0] WS_UP   = 2'b10;
    localparam logic [1:0] WS_FULL = 2'b11;

    localparam logic [4:0] BITS_FULL = 5'd16;
    localparam logic [4:0] BITS_BYTE = 5'd8;

    localparam int TIMER_WIDTH = 4;

    // Number of serial bits the serializer emits for a given word-select.
    function automatic logic [4:0] bits_for(input logic [1:0] ws);
        logic [4:0] bits;
        case (ws)
            WS_FULL:        bits = BITS_FULL;
            WS_LOW, WS_UP:  bits = BITS_BYTE;
            default:        bits = 5'd0;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/mram_read_timer.sv
// Loadable down-counter used to time the asynchronous MRAM access window.
//   clk_i, rst_i  : clock, synchronous active-high reset
//   load_i        : load load_val_i (takes priority over dec_i)
//   load_val_i    : number of cycles to wait
//   dec_i         : count down by one while non-zero
//   expire_o      : high during the last cycle of the wait window
module mram_read_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             dec_i,
    output logic             expire_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    // Next count: load wins, otherwise decrement and saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - WIDTH'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Count register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // A count of one means this is the final cycle of the window.
    assign expire_o = (cnt_q == WIDTH'(1));

endmodule

// File: rtl/mram_burst_read_ctrl.sv
// Burst read sequencer feeding the parallel-to-serial stage.
// Reads burst_len consecutive words from an asynchronous SRAM-style MRAM,
// loads each into the serializer and strobes ser_send once per bit.
//   clk, rst                          : clock, synchronous active-high reset
//   start, abort                      : burst request / unconditional stop
//   start_addr, burst_len, word_sel_in: burst parameters, latched at accept
//   busy, done, err                   : status (done/err are 1-cycle pulses)
//   mram_*                            : MRAM address and active-low controls
//   ser_en, ser_load, ser_send        : serializer control strobes
//   ser_word_sel                      : latched word-select for the serializer
// All outputs are registered and decoded from the next state, so they line
// up with the state the FSM is in during that cycle.
module mram_burst_read_ctrl
    import mram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 18,
    parameter int BUS_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8,
    parameter int READ_WAIT  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [LEN_WIDTH-1:0]  burst_len,
    input  logic [1:0]            word_sel_in,
    output logic                  busy,
    output logic                  done,
    output logic                  err,
    output logic [ADDR_WIDTH-1:0] mram_addr,
    output logic                  mram_ce_n,
    output logic                  mram_oe_n,
    output logic                  mram_we_n,
    output logic                  mram_ub_n,
    output logic                  mram_lb_n,
    output logic                  ser_en,
    output logic                  ser_load,
    output logic                  ser_send,
    output logic [1:0]            ser_word_sel
);

    if (BUS_WIDTH != int'(BITS_FULL)) begin : g_bus_width_check
        $error("BUS_WIDTH must match the serializer word width");
    end
    if ((READ_WAIT < 1) || (READ_WAIT > 15)) begin : g_read_wait_check
        $error("READ_WAIT must be in 1..15");
    end

    localparam logic [TIMER_WIDTH-1:0] WAIT_LOAD = TIMER_WIDTH'(READ_WAIT);

    state_e                state_q,  state_d;
    logic [ADDR_WIDTH-1:0] addr_q,   addr_d;
    logic [LEN_WIDTH-1:0]  rem_q,    rem_d;
    logic [4:0]            bit_q,    bit_d;
    logic [1:0]            ws_q,     ws_d;
    logic                  err_d;
    logic                  tmr_load_s;
    logic                  tmr_dec_s;
    logic                  tmr_expire_s;
    logic                  mem_en_s;

    logic busy_q, done_q, err_q, ce_n_q, oe_n_q, ub_n_q, lb_n_q, load_q, send_q;

    mram_read_timer #(
        .WIDTH (TIMER_WIDTH)
    ) u_timer (
        .clk_i      (clk),
        .rst_i      (rst),
        .load_i     (tmr_load_s),
        .load_val_i (WAIT_LOAD),
        .dec_i      (tmr_dec_s),
        .expire_o   (tmr_expire_s)
    );

    // Next-state and datapath logic; abort overrides every state.
    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        rem_d      = rem_q;
        bit_d      = bit_q;
        ws_d       = ws_q;
        err_d      = 1'b0;
        tmr_load_s = 1'b0;
        tmr_dec_s  = 1'b0;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (word_sel_in == WS_NONE) begin
                            err_d = 1'b1;
                        end else if (burst_len == '0) begin
                            state_d = ST_DONE;
                        end else begin
                            ws_d       = word_sel_in;
                            addr_d     = start_addr;
                            rem_d      = burst_len;
                            tmr_load_s = 1'b1;
                            state_d    = ST_ADDR;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_ADDR: begin
                    tmr_dec_s = 1'b1;
                    if (tmr_expire_s) begin
                        state_d = ST_LOAD;
                    end else begin
                        state_d = ST_ADDR;
                    end
                end
                ST_LOAD: begin
                    bit_d   = bits_for(ws_q);
                    state_d = ST_SHIFT;
                end
                ST_SHIFT: begin
                    bit_d = bit_q - 5'd1;
                    if (bit_q == 5'd1) begin
                        state_d = ST_NEXT;
                    end else begin
                        state_d = ST_SHIFT;
                    end
                end
                ST_NEXT: begin
                    // Address advances even after the last word; it wraps naturally.
                    addr_d = addr_q + ADDR_WIDTH'(1);
                    rem_d  = rem_q - LEN_WIDTH'(1);
                    if (rem_q == LEN_WIDTH'(1)) begin
                        state_d = ST_DONE;
                    end else begin
                        tmr_load_s = 1'b1;
                        state_d    = ST_ADDR;
                    end
                end
                ST_DONE: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    // MRAM stays selected through LOAD so the data is stable while captured.
    always_comb begin
        if ((state_d == ST_ADDR) || (state_d == ST_LOAD)) begin
            mem_en_s = 1'b1;
        end else begin
            mem_en_s = 1'b0;
        end
    end

    // State, datapath and registered output decode.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            bit_q   <= 5'd0;
            ws_q    <= 2'b00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            load_q  <= 1'b0;
            send_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            bit_q   <= bit_d;
            ws_q    <= ws_d;
            busy_q  <= (state_d != ST_IDLE);
            done_q  <= (state_d == ST_DONE);
            err_q   <= err_d;
            ce_n_q  <= ~mem_en_s;
            oe_n_q  <= ~mem_en_s;
            ub_n_q  <= ~(mem_en_s & ws_d[1]);
            lb_n_q  <= ~(mem_en_s & ws_d[0]);
            load_q  <= (state_d == ST_LOAD);
            send_q  <= (state_d == ST_SHIFT);
        end
    end

    assign busy         = busy_q;
    assign ser_en       = busy_q;
    assign done         = done_q;
    assign err          = err_q;
    assign mram_addr    = addr_q;
    assign mram_ce_n    = ce_n_q;
    assign mram_oe_n    = oe_n_q;
    assign mram_we_n    = 1'b1;
    assign mram_ub_n    = ub_n_q;
    assign mram_lb_n    = lb_n_q;
    assign ser_load     = load_q;
    assign ser_send     = send_q;
    assign ser_word_sel = ws_q;

endmodule

// File: tb/tb_mram_burst_read_ctrl.sv
module tb_mram_burst_read_ctrl;

    localparam int AW = 18;
    localparam int LW = 8;
    localparam int RW = 3;

    logic          clk = 1'b0;
    logic          rst, start, abort;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] burst_len;
    logic [1:0]    word_sel_in;
    logic          busy, done, err, mram_ce_n, mram_oe_n, mram_we_n;
    logic          mram_ub_n, mram_lb_n, ser_en, ser_load, ser_send;
    logic [AW-1:0] mram_addr;
    logic [1:0]    ser_word_sel;

    always #5 clk = ~clk;

    mram_burst_read_ctrl #(
        .ADDR_WIDTH (AW),
        .BUS_WIDTH  (16),
        .LEN_WIDTH  (LW),
        .READ_WAIT  (RW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .abort        (abort),
        .start_addr   (start_addr),
        .burst_len    (burst_len),
        .word_sel_in  (word_sel_in),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .mram_addr    (mram_addr),
        .mram_ce_n    (mram_ce_n),
        .mram_oe_n    (mram_oe_n),
        .mram_we_n    (mram_we_n),
        .mram_ub_n    (mram_ub_n),
        .mram_lb_n    (mram_lb_n),
        .ser_en       (ser_en),
        .ser_load     (ser_load),
        .ser_send     (ser_send),
        .ser_word_sel (ser_word_sel)
    );

    int n_checks = 0;
    int n_errors = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    // ---------------- behavioural reference model ----------------
    // A burst is described by its cycle offset t since acceptance; each word
    // occupies RW + 1 + bits + 1 cycles, and the DONE cycle follows the last.
    bit            m_active = 1'b0;
    bit            m_err    = 1'b0;
    int            m_t, m_len, m_bits, m_total;
    logic [AW-1:0] m_base;
    logic [AW-1:0] m_addr = '0;
    logic [1:0]    m_ws   = 2'b00;

    task automatic model_step();
        if (rst) begin
            m_active = 1'b0; m_err = 1'b0; m_addr = '0; m_ws = 2'b00;
        end else begin
            m_err = 1'b0;
            if (abort) begin
                m_active = 1'b0;
            end else if (m_active) begin
                m_t++;
                if (m_t > m_total) m_active = 1'b0;
            end else if (start) begin
                if (word_sel_in == 2'b00) begin
                    m_err = 1'b1;
                end else if (burst_len == '0) begin
                    m_active = 1'b1; m_t = 1; m_len = 0; m_total = 1;
                end else begin
                    m_active = 1'b1; m_t = 1; m_len = int'(burst_len);
                    m_ws = word_sel_in; m_base = start_addr;
                    m_bits = (word_sel_in == 2'b11) ? 16 : 8;
                    m_total = m_len * (RW + 2 + m_bits) + 1;
                end
            end
            if (m_active && m_len > 0)
                m_addr = m_base + AW'((m_t - 1) / (RW + 2 + m_bits));
        end
    endtask

    // {busy, ser_en, done, err, ce_n, oe_n, we_n, ub_n, lb_n, load, send}
    function automatic logic [10:0] model_ctl();
        bit a_s = 1'b0, l_s = 1'b0, s_s = 1'b0, d_s = 1'b0, en;
        int p;
        if (m_active) begin
            if (m_t == m_total) begin
                d_s = 1'b1;
            end else begin
                p = (m_t - 1) % (RW + 2 + m_bits);
                if (p < RW)                 a_s = 1'b1;
                else if (p == RW)           l_s = 1'b1;
                else if (p <= RW + m_bits)  s_s = 1'b1;
            end
        end
        en = a_s | l_s;
        return {m_active, m_active, d_s, m_err, !en, !en, 1'b1,
                !(en && m_ws[1]), !(en && m_ws[0]), l_s, s_s};
    endfunction

    // Cycle-by-cycle comparison against the model.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("cyc_ctl", 32'({busy, ser_en, done, err, mram_ce_n, mram_oe_n, mram_we_n,
                            mram_ub_n, mram_lb_n, ser_load, ser_send}), 32'(model_ctl()));
        chk("cyc_addr", 32'(mram_addr), 32'(m_addr));
        chk("cyc_ws", 32'(ser_word_sel), 32'(m_ws));
    end

    // ---------------- table-driven bursts ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [LW-1:0] len;
        logic [1:0]    ws;
        int sends, dones, errs, loads, ce_lows, ub_lows, lb_lows, busys;
        logic [AW-1:0] first_ld, last_ld;
    } vec_t;

    vec_t tbl[6];

    task automatic do_burst(input vec_t v, output vec_t r);
        bit fin = 1'b0;
        r = v;
        r.sends = 0; r.dones = 0; r.errs = 0; r.loads = 0; r.ce_lows = 0;
        r.ub_lows = 0; r.lb_lows = 0; r.busys = 0; r.first_ld = '0; r.last_ld = '0;
        @(negedge clk);
        start_addr = v.addr; burst_len = v.len; word_sel_in = v.ws; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= 3000; k++) begin
            if (ser_send)   r.sends++;
            if (done)       r.dones++;
            if (err)        r.errs++;
            if (!mram_ce_n) r.ce_lows++;
            if (!mram_ub_n) r.ub_lows++;
            if (!mram_lb_n) r.lb_lows++;
            if (busy)       r.busys++;
            if (ser_load) begin
                r.loads++;
                if (r.loads == 1) r.first_ld = mram_addr;
                r.last_ld = mram_addr;
            end
            if (k >= 2 && !busy) begin fin = 1'b1; break; end
            @(negedge clk);
        end
        chk("burst_end", 32'(fin), 32'd1);
    endtask

    vec_t r;
    int   first_send, last_send, done_at, idle_at, load_at, ce_first, n_send, n_done, n_err;
    bit   hit;

    initial begin
        tbl[0] = '{18'h00010, 8'd1, 2'b11, 16, 1, 0, 1,  4, 4,  4,  22, 18'h00010, 18'h00010};
        tbl[1] = '{18'h00010, 8'd3, 2'b01, 24, 1, 0, 3, 12, 0, 12,  40, 18'h00010, 18'h00012};
        tbl[2] = '{18'h3FFFF, 8'd2, 2'b11, 32, 1, 0, 2,  8, 8,  8,  43, 18'h3FFFF, 18'h00000};
        tbl[3] = '{18'h00100, 8'd2, 2'b10, 16, 1, 0, 2,  8, 8,  0,  27, 18'h00100, 18'h00101};
        tbl[4] = '{18'h00055, 8'd0, 2'b11,  0, 1, 0, 0,  0, 0,  0,   1, 18'h00000, 18'h00000};
        tbl[5] = '{18'h00020, 8'd4, 2'b00,  0, 0, 1, 0,  0, 0,  0,   0, 18'h00000, 18'h00000};

        rst = 1'b1; start = 1'b0; abort = 1'b0;
        start_addr = '0; burst_len = '0; word_sel_in = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_ctl", 32'({busy, done, err, mram_ce_n, mram_oe_n, mram_we_n, mram_ub_n,
                            mram_lb_n, ser_en, ser_load, ser_send}), 32'b00011111000);
        chk("rst_addr", 32'(mram_addr), 32'd0);
        rst = 1'b0;

        // Exact cycle positions for a single full word.
        @(negedge clk);
        start_addr = 18'h00010; burst_len = 8'd1; word_sel_in = 2'b11; start = 1'b1;
        first_send = 0; last_send = 0; done_at = 0; idle_at = 0; load_at = 0; ce_first = 0;
        @(posedge clk);
        for (int k = 1; k <= 24; k++) begin
            #1;
            if (ser_send && first_send == 0) first_send = k;
            if (ser_send) last_send = k;
            if (ser_load) load_at = k;
            if (!mram_ce_n && ce_first == 0) ce_first = k;
            if (done) done_at = k;
            if (!busy && idle_at == 0) idle_at = k;
            @(negedge clk);
            start = 1'b0;
            @(posedge clk);
        end
        chk("t_ce_first", 32'(ce_first), 32'd1);
        chk("t_load", 32'(load_at), 32'd4);
        chk("t_send_first", 32'(first_send), 32'd5);
        chk("t_send_last", 32'(last_send), 32'd20);
        chk("t_done", 32'(done_at), 32'd22);
        chk("t_idle", 32'(idle_at), 32'd23);

        // Table of bursts.
        for (int i = 0; i < 6; i++) begin
            do_burst(tbl[i], r);
            chk($sformatf("v%0d_sends", i), 32'(r.sends), 32'(tbl[i].sends));
            chk($sformatf("v%0d_dones", i), 32'(r.dones), 32'(tbl[i].dones));
            chk($sformatf("v%0d_errs", i), 32'(r.errs), 32'(tbl[i].errs));
            chk($sformatf("v%0d_loads", i), 32'(r.loads), 32'(tbl[i].loads));
            chk($sformatf("v%0d_ce", i), 32'(r.ce_lows), 32'(tbl[i].ce_lows));
            chk($sformatf("v%0d_ub", i), 32'(r.ub_lows), 32'(tbl[i].ub_lows));
            chk($sformatf("v%0d_lb", i), 32'(r.lb_lows), 32'(tbl[i].lb_lows));
            chk($sformatf("v%0d_busy", i), 32'(r.busys), 32'(tbl[i].busys));
            if (tbl[i].loads > 0) begin
                chk($sformatf("v%0d_ld0", i), 32'(r.first_ld), 32'(tbl[i].first_ld));
                chk($sformatf("v%0d_ldN", i), 32'(r.last_ld), 32'(tbl[i].last_ld));
            end
        end

        // Abort on the 5th send of word 2, with a start in the same cycle.
        @(negedge clk);
        start_addr = 18'h00040; burst_len = 8'd3; word_sel_in = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_send = 0; hit = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (ser_send) n_send++;
            if (n_send == 21) begin
                abort = 1'b1; start = 1'b1; burst_len = 8'd1; hit = 1'b1;
                @(negedge clk);
                abort = 1'b0; start = 1'b0;
                break;
            end
            @(negedge clk);
        end
        chk("ab_reached", 32'(hit), 32'd1);
        chk("ab_ctl", 32'({busy, ser_send, ser_load, mram_ce_n, mram_oe_n, done, err}), 32'b0001100);
        n_done = 0;
        for (int k = 0; k < 5; k++) begin
            if (done || busy) n_done++;
            @(negedge clk);
        end
        chk("ab_quiet", 32'(n_done), 32'd0);
        do_burst(tbl[0], r);
        chk("ab_restart_sends", 32'(r.sends), 32'd16);
        chk("ab_restart_done", 32'(r.dones), 32'd1);

        // Reset during ADDR, then a second start during SHIFT.
        @(negedge clk);
        start_addr = 18'h00123; burst_len = 8'd2; word_sel_in = 2'b11; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        chk("rs_in_addr", 32'({busy, mram_ce_n}), 32'b10);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rs_ctl", 32'({busy, done, err, mram_ce_n, mram_oe_n, mram_we_n, mram_ub_n,
                           mram_lb_n, ser_en, ser_load, ser_send}), 32'b00011111000);
        chk("rs_addr", 32'(mram_addr), 32'd0);
        chk("rs_ws", 32'(ser_word_sel), 32'd0);
        start_addr = 18'h00200; burst_len = 8'd1; word_sel_in = 2'b01; start = 1'b1;
        @(negedge clk);
        start = 1'b0; n_send = 0; n_done = 0; n_err = 0; hit = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            if (ser_send) n_send++;
            if (done) n_done++;
            if (err) n_err++;
            if (n_send == 2 && !hit) begin
                start = 1'b1; word_sel_in = 2'b00; hit = 1'b1;
            end else begin
                start = 1'b0;
            end
            if (k >= 2 && !busy) break;
            @(negedge clk);
        end
        chk("rs_sends", 32'(n_send), 32'd8);
        chk("rs_done", 32'(n_done), 32'd1);
        chk("rs_noerr", 32'(n_err), 32'd0);

        // Random traffic against the model.
        for (int k = 0; k < 4000; k++) begin
            @(negedge clk);
            start       = ($urandom_range(0, 15) == 0);
            abort       = ($urandom_range(0, 199) == 0);
            rst         = ($urandom_range(0, 1499) == 0);
            burst_len   = LW'($urandom_range(0, 3));
            word_sel_in = 2'($urandom_range(0, 3));
            start_addr  = ($urandom_range(0, 1) == 0) ? AW'(18'h3FFFE + 18'($urandom_range(0, 1)))
                                                      : AW'($urandom);
        end
        @(negedge clk);
        start = 1'b0; abort = 1'b0; rst = 1'b0;
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
